mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- 32 x 32-bit MIPS general-purpose register file with a separate HI/LO register pair.
- Sits directly downstream of the 5-bit register-destination 2:1 mux (rt/rd select), which drives its write address.
- Two combinational read ports feed the ALU operand path. One synchronous write port is driven by the write-back stage.
- Exposes $v0 as a debug/result output for the CPU top level.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)
BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
read_addr_a  input  ADDR_W  read port A address (rs)
read_addr_b  input  ADDR_W  read port B address (rt)
read_data_a  output  DATA_W  read port A data, combinational
read_data_b  output  DATA_W  read port B data, combinational
write_addr  input  ADDR_W  write address, from register-destination mux output
write_data  input  DATA_W  write-back data
write_enable  input  1  GPR write strobe, sampled on rising clk
hi_lo_write_enable  input  1  HI/LO write strobe (MULT/DIV/MTHI/MTLO path)
hi_in  input  DATA_W  next HI value
lo_in  input  DATA_W  next LO value
hi_out  output  DATA_W  current HI, registered
lo_out  output  DATA_W  current LO, registered
register_v0  output  DATA_W  current contents of register 2, registered, never bypassed

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset:
  - While rst_n=0, all 32 GPRs, HI and LO are forced to 0 immediately, independent of clk.
  - Therefore read_data_a/b, hi_out, lo_out and register_v0 all read 0 during reset.
  - Writes presented while rst_n=0 are discarded.
  - Writes resume on the first rising clk edge with rst_n=1.
- GPR write:
  - On rising clk, if write_enable=1 and write_addr!=0, reg[write_addr] <= write_data.
  - Write latency is 1 cycle: the stored value is visible via the non-bypassed path from the next cycle.
- Register $0:
  - Always reads 0.
  - Writes to address 0 are silently dropped and never forwarded, including with BYPASS=1.
- Reads:
  - Purely combinational from the read address.
  - Both ports are independent; both may address the same register.
- Bypass (BYPASS=1):
  - If write_enable=1, write_addr!=0 and write_addr==read_addr_x in the same cycle, read_data_x = write_data (not the old stored value).
  - This applies to each port independently.
- BYPASS=0: reads return the pre-edge stored value during the write cycle.
- HI/LO:
  - On rising clk, if hi_lo_write_enable=1, HI <= hi_in and LO <= lo_in, both in the same edge.
  - HI/LO are independent of the GPR write; both writes may occur in the same cycle.
  - hi_out/lo_out are never bypassed.
- register_v0 always reflects the stored reg[2], with no forwarding.
- Undriven/X write_addr with write_enable=0 must not corrupt any register.
- Reset asserted mid-write (rst_n falls in the same cycle as a write): reset wins, and the register reads 0 afterwards.

Test Plan:
- Reset sequence: rst_n=0 for 2 cycles -> read_data_a/b, hi_out, lo_out, register_v0 all 32'h0; with write_enable=1, write_addr=5'd3, write_data=32'hDEADBEEF during reset -> reg 3 still 0 after release.
- Basic write/read: write 32'h12345678 to reg 5'd17, next cycle read_addr_a=17 -> read_data_a=32'h12345678; read_addr_b=5'd2 -> 0.
- $0 immunity: write_enable=1, write_addr=0, write_data=32'hFFFFFFFF with read_addr_a=0 in same cycle and after -> read_data_a=0 both cycles.
- Bypass: reg 9 holds 32'h1; same cycle write_addr=9, write_data=32'hA5A5A5A5, read_addr_a=read_addr_b=9 -> both read 32'hA5A5A5A5 with BYPASS=1; with BYPASS=0 -> 32'h1 until the edge, then 32'hA5A5A5A5.
- $v0 and HI/LO: write 32'h0000002A to reg 2 together with hi_lo_write_enable=1, hi_in=32'h1, lo_in=32'h2 -> after the edge register_v0=32'h2A, hi_out=1, lo_out=2; register_v0 unchanged (0) in the write cycle itself.
- Async reset mid-run: after the above, pull rst_n low between clock edges -> all outputs 0 before the next rising clk.

Source files
------------

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - MIPS 32 x 32-bit general-purpose register file with HI/LO pair
//
// Purpose:
//   General-purpose register file for the MIPS datapath. It has two
//   combinational read ports and one synchronous write port. Same-cycle
//   write-to-read forwarding is optional. A separate HI/LO register pair
//   serves the multiply/divide path, and register 2 ($v0) is exposed for
//   debug.
//
// Ports:
//   clk                 system clock, all state updates on rising edge
//   rst_n               asynchronous active-low reset, clears every register
//   read_addr_a/b       read port addresses (rs / rt)
//   read_data_a/b       combinational read data
//   write_addr          GPR write address (from register-destination mux)
//   write_data          GPR write-back data
//   write_enable        GPR write strobe
//   hi_lo_write_enable  HI/LO write strobe, loads hi_in and lo_in together
//   hi_in, lo_in        next HI / LO values
//   hi_out, lo_out      registered HI / LO
//   register_v0         stored contents of register 2, never forwarded

module mips_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    input  logic              hi_lo_write_enable,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] register_v0
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Writes aimed at $0 are dropped here. The drop applies to both the
    // storage path and the forwarding path, so $0 can never appear non-zero.
    logic gpr_wr;
    assign gpr_wr = write_enable && (write_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (gpr_wr) begin
                regs[write_addr] <= write_data;
            end
            if (hi_lo_write_enable) begin
                hi_q <= hi_in;
                lo_q <= lo_in;
            end
        end
    end

    // Forwarding is gated by rst_n. Otherwise a write presented during
    // reset would leak onto the read ports, even though that write is discarded.
    logic fwd_a;
    logic fwd_b;
    assign fwd_a = BYPASS && rst_n && gpr_wr && (write_addr == read_addr_a);
    assign fwd_b = BYPASS && rst_n && gpr_wr && (write_addr == read_addr_b);

    always_comb begin
        read_data_a = regs[read_addr_a];
        if (read_addr_a == '0) begin
            read_data_a = '0;
        end else if (fwd_a) begin
            read_data_a = write_data;
        end
    end

    always_comb begin
        read_data_b = regs[read_addr_b];
        if (read_addr_b == '0) begin
            read_data_b = '0;
        end else if (fwd_b) begin
            read_data_b = write_data;
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign register_v0 = regs[2];

endmodule

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - self-checking bench for mips_reg_file, BYPASS=1 and BYPASS=0 side by side

module tb_mips_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic        hi_lo_write_enable;
    logic [31:0] hi_in;
    logic [31:0] lo_in;

    logic [31:0] rda_1, rdb_1, hi_1, lo_1, v0_1;
    logic [31:0] rda_0, rdb_0, hi_0, lo_0, v0_0;

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_1), .read_data_b(rdb_1),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .hi_lo_write_enable(hi_lo_write_enable), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(hi_1), .lo_out(lo_1), .register_v0(v0_1)
    );

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_0), .read_data_b(rdb_0),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .hi_lo_write_enable(hi_lo_write_enable), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(hi_0), .lo_out(lo_0), .register_v0(v0_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register contents.
    logic [31:0] mdl_gpr [32];
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl_gpr[i] = 32'h0;
        mdl_hi = 32'h0;
        mdl_lo = 32'h0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && write_enable && write_addr == a) return write_data;
        return mdl_gpr[a];
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_rda_byp"},   rda_1, exp_read(read_addr_a, 1'b1));
        check({ph, "_rdb_byp"},   rdb_1, exp_read(read_addr_b, 1'b1));
        check({ph, "_rda_nobyp"}, rda_0, exp_read(read_addr_a, 1'b0));
        check({ph, "_rdb_nobyp"}, rdb_0, exp_read(read_addr_b, 1'b0));
        check({ph, "_hi_byp"},    hi_1,  mdl_hi);
        check({ph, "_lo_byp"},    lo_1,  mdl_lo);
        check({ph, "_v0_byp"},    v0_1,  mdl_gpr[2]);
        check({ph, "_hi_nobyp"},  hi_0,  mdl_hi);
        check({ph, "_lo_nobyp"},  lo_0,  mdl_lo);
        check({ph, "_v0_nobyp"},  v0_0,  mdl_gpr[2]);
    endtask

    // Advance one rising edge and apply the architectural effect of the
    // inputs that were presented during the cycle.
    task automatic clock_edge();
        @(posedge clk);
        if (rst_n) begin
            if (write_enable && write_addr != 5'd0) mdl_gpr[write_addr] = write_data;
            if (hi_lo_write_enable) begin
                mdl_hi = hi_in;
                mdl_lo = lo_in;
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        #3 check_all({tag, "_pre"});
        clock_edge();
        check_all({tag, "_post"});
    endtask

    task automatic idle_inputs();
        write_enable       = 1'b0;
        hi_lo_write_enable = 1'b0;
        write_addr         = 5'd0;
        write_data         = 32'h0;
        hi_in              = 32'h0;
        lo_in              = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        mdl_clear();
        idle_inputs();
        read_addr_a = 5'd3;
        read_addr_b = 5'd3;
        @(posedge clk);
        #1;

        // Reset: a write presented during reset is discarded.
        write_enable = 1'b1;
        write_addr   = 5'd3;
        write_data   = 32'hDEADBEEF;
        step("rst0");
        step("rst1");
        rst_n = 1'b1;
        idle_inputs();
        #3 check("rst_r3_a", rda_1, 32'h0);
        check("rst_r3_b", rdb_0, 32'h0);
        clock_edge();

        // Basic write and read back.
        write_enable = 1'b1;
        write_addr   = 5'd17;
        write_data   = 32'h12345678;
        step("wr17");
        idle_inputs();
        read_addr_a = 5'd17;
        read_addr_b = 5'd2;
        #3 check("rd17_a", rda_0, 32'h12345678);
        check("rd2_b", rdb_0, 32'h0);
        clock_edge();

        // $0 stays zero, even with forwarding enabled.
        write_enable = 1'b1;
        write_addr   = 5'd0;
        write_data   = 32'hFFFFFFFF;
        read_addr_a  = 5'd0;
        read_addr_b  = 5'd0;
        #3 check("r0_same_byp", rda_1, 32'h0);
        check("r0_same_nobyp", rda_0, 32'h0);
        clock_edge();
        idle_inputs();
        #3 check("r0_after_byp", rda_1, 32'h0);
        check("r0_after_nobyp", rdb_0, 32'h0);
        clock_edge();

        // Forwarding: reg 9 holds 1, then 0xA5A5A5A5 is written while it is read.
        write_enable = 1'b1;
        write_addr   = 5'd9;
        write_data   = 32'h1;
        step("wr9");
        write_data   = 32'hA5A5A5A5;
        read_addr_a  = 5'd9;
        read_addr_b  = 5'd9;
        #3 check("byp_a", rda_1, 32'hA5A5A5A5);
        check("byp_b", rdb_1, 32'hA5A5A5A5);
        check("nobyp_a_old", rda_0, 32'h1);
        check("nobyp_b_old", rdb_0, 32'h1);
        clock_edge();
        idle_inputs();
        #3 check("nobyp_a_new", rda_0, 32'hA5A5A5A5);
        check("nobyp_b_new", rdb_0, 32'hA5A5A5A5);
        clock_edge();

        // $v0 and HI/LO are updated on the same edge, and neither is forwarded.
        write_enable       = 1'b1;
        write_addr         = 5'd2;
        write_data         = 32'h0000002A;
        hi_lo_write_enable = 1'b1;
        hi_in              = 32'h1;
        lo_in              = 32'h2;
        #3 check("v0_wrcycle", v0_1, 32'h0);
        check("hi_wrcycle", hi_1, 32'h0);
        clock_edge();
        check("v0_after", v0_1, 32'h2A);
        check("hi_after", hi_1, 32'h1);
        check("lo_after", lo_0, 32'h2);
        idle_inputs();

        // Asynchronous reset between edges clears everything before the next edge.
        read_addr_a = 5'd17;
        read_addr_b = 5'd9;
        #2 rst_n = 1'b0;
        mdl_clear();
        #1 check("async_v0", v0_1, 32'h0);
        check("async_hi", hi_0, 32'h0);
        check("async_rda", rda_1, 32'h0);
        check("async_rdb", rdb_0, 32'h0);
        check_all("async");
        clock_edge();
        rst_n = 1'b1;
        clock_edge();

        // Randomized traffic with address collisions and occasional reset.
        for (int n = 0; n < 600; n++) begin
            write_enable       = ($urandom_range(0, 3) != 0);
            write_addr         = 5'($urandom_range(0, 31));
            write_data         = $urandom;
            hi_lo_write_enable = ($urandom_range(0, 3) == 0);
            hi_in              = $urandom;
            lo_in              = $urandom;
            read_addr_a        = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
            read_addr_b        = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) read_addr_a = 5'd2;
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                mdl_clear();
            end else begin
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
